// File: rtl/mdu_unit.sv
// Execute-stage multiply/divide unit owning the HI/LO registers, with a busy counter modelling latency.
// Optional madd/msub accumulate ops (codes 9/10) are enabled by defining MDU_MADD_EN.
module mdu_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  MDUOpE,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Req,
  output logic        Start,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDUOut
);

  localparam int unsigned DW      = 32;
  localparam int unsigned CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MSUB  = 4'd10;
`endif

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [DW-1:0]      hi_nxt, lo_nxt;
  logic [DW-1:0]      hi_tmp, lo_tmp, hi_tmp_nxt, lo_tmp_nxt;
  logic               wb_en, wb_en_nxt;

  logic [2*DW-1:0]    prod_s, prod_u;
  logic               a_neg, b_neg;
  logic [DW-1:0]      a_mag, b_mag, q_mag, r_mag, q_s, r_s, q_u, r_u;
  logic               is_mult, is_div, is_macc, start_op;

  // Full-width products; the sign-extended operands make the 64-bit truncation exact.
  assign prod_s = $signed({{DW{A[DW-1]}}, A}) * $signed({{DW{B[DW-1]}}, B});
  assign prod_u = {{DW{1'b0}}, A} * {{DW{1'b0}}, B};

  // Signed division via magnitudes, so the most-negative / -1 case wraps cleanly.
  assign a_neg = A[DW-1];
  assign b_neg = B[DW-1];
  assign a_mag = a_neg ? (~A + DW'(1)) : A;
  assign b_mag = b_neg ? (~B + DW'(1)) : B;
  assign q_mag = (B == '0) ? '0 : a_mag / b_mag;
  assign r_mag = (B == '0) ? '0 : a_mag % b_mag;
  assign q_s   = (a_neg ^ b_neg) ? (~q_mag + DW'(1)) : q_mag;
  assign r_s   = a_neg ? (~r_mag + DW'(1)) : r_mag;
  assign q_u   = (B == '0) ? '0 : A / B;
  assign r_u   = (B == '0) ? '0 : A % B;

  assign is_mult = (MDUOpE == OP_MULT) || (MDUOpE == OP_MULTU);
  assign is_div  = (MDUOpE == OP_DIV)  || (MDUOpE == OP_DIVU);
`ifdef MDU_MADD_EN
  assign is_macc = (MDUOpE == OP_MADD) || (MDUOpE == OP_MSUB);
`else
  assign is_macc = 1'b0;
`endif
  assign start_op = is_mult || is_div || is_macc;

  assign Busy   = (state == RUN);
  assign Start  = start_op && !Req && !Busy;
  assign MDUOut = (MDUOpE == OP_MFHI) ? HI :
                  (MDUOpE == OP_MFLO) ? LO : '0;

  // Next-state and register updates.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    hi_nxt     = HI;
    lo_nxt     = LO;
    hi_tmp_nxt = hi_tmp;
    lo_tmp_nxt = lo_tmp;
    wb_en_nxt  = wb_en;
    case (state)
      IDLE: begin
        if (Start) begin
          state_nxt = RUN;
          wb_en_nxt = 1'b1;
          cnt_nxt   = CNT_W'(MULT_CYCLES);
          case (MDUOpE)
            OP_MULT:  {hi_tmp_nxt, lo_tmp_nxt} = prod_s;
            OP_MULTU: {hi_tmp_nxt, lo_tmp_nxt} = prod_u;
            OP_DIV: begin
              {hi_tmp_nxt, lo_tmp_nxt} = {r_s, q_s};
              cnt_nxt   = CNT_W'(DIV_CYCLES);
              wb_en_nxt = (B != '0);
            end
            OP_DIVU: begin
              {hi_tmp_nxt, lo_tmp_nxt} = {r_u, q_u};
              cnt_nxt   = CNT_W'(DIV_CYCLES);
              wb_en_nxt = (B != '0);
            end
`ifdef MDU_MADD_EN
            // Accumulate base is the architectural HI/LO at the Start edge.
            OP_MADD:  {hi_tmp_nxt, lo_tmp_nxt} = {HI, LO} + prod_s;
            OP_MSUB:  {hi_tmp_nxt, lo_tmp_nxt} = {HI, LO} - prod_s;
`endif
            default: ;
          endcase
        end else if (!Req) begin
          if (MDUOpE == OP_MTHI) hi_nxt = A;
          if (MDUOpE == OP_MTLO) lo_nxt = A;
        end
      end
      RUN: begin
        cnt_nxt = cnt - CNT_W'(1);
        if (cnt <= CNT_W'(1)) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          if (wb_en) begin
            hi_nxt = hi_tmp;
            lo_nxt = lo_tmp;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      HI     <= '0;
      LO     <= '0;
      hi_tmp <= '0;
      lo_tmp <= '0;
      wb_en  <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      HI     <= hi_nxt;
      LO     <= lo_nxt;
      hi_tmp <= hi_tmp_nxt;
      lo_tmp <= lo_tmp_nxt;
      wb_en  <= wb_en_nxt;
    end
  end

endmodule

// File: tb/tb_mdu_unit.sv
// Self-checking bench for mdu_unit: directed scenarios plus randomized ops against a timeline model.
module tb_mdu_unit;

  localparam int unsigned MULT_N = 5;
  localparam int unsigned DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  op;
  logic [31:0] a_in, b_in;
  logic        req;
  logic        start, busy;
  logic [31:0] hi, lo, mdu_out;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: architectural HI/LO plus one pending result with its completion cycle.
  int          cyc    = 0;
  int          m_done = 0;
  bit          m_pend = 1'b0;
  logic [63:0] m_res  = '0;
  logic [31:0] m_hi   = '0;
  logic [31:0] m_lo   = '0;

  mdu_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset), .MDUOpE(op), .A(a_in), .B(b_in), .Req(req),
    .Start(start), .Busy(busy), .HI(hi), .LO(lo), .MDUOut(mdu_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_start_op(input logic [3:0] o);
`ifdef MDU_MADD_EN
    return (o >= 4'd1 && o <= 4'd4) || o == 4'd9 || o == 4'd10;
`else
    return (o >= 4'd1 && o <= 4'd4);
`endif
  endfunction

  function automatic int latency(input logic [3:0] o);
    return (o == 4'd3 || o == 4'd4) ? int'(DIV_N) : int'(MULT_N);
  endfunction

  // Architectural result {HI,LO} from plain 64-bit arithmetic.
  function automatic logic [63:0] ref_result(input logic [3:0] o, input logic [31:0] a,
                                             input logic [31:0] b, input logic [63:0] base);
    longint          sa, sb, q, r;
    longint unsigned ua, ub;
    logic [63:0]     qq, rr, p;
    sa = longint'(int'(a));
    sb = longint'(int'(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    p  = sa * sb;
    case (o)
      4'd1: return p;
      4'd2: return ua * ub;
      4'd3: begin
        if (sb == 0) return base;
        q = sa / sb; r = sa % sb; qq = q; rr = r;
        return {rr[31:0], qq[31:0]};
      end
      4'd4: begin
        if (ub == 0) return base;
        qq = ua / ub; rr = ua % ub;
        return {rr[31:0], qq[31:0]};
      end
      4'd9:  return base + p;
      4'd10: return base - p;
      default: return base;
    endcase
  endfunction

  // One clock: drive at negedge, check combinational outputs, advance model at posedge, check state.
  task automatic step(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b, input logic r);
    bit          exp_start;
    logic [31:0] exp_out;
    @(negedge clk);
    op = o; a_in = a; b_in = b; req = r;
    #1;
    exp_start = is_start_op(o) && !r && !(cyc < m_done);
    exp_out   = (o == 4'd5) ? m_hi : (o == 4'd6) ? m_lo : 32'h0;
    check("start", 32'(start), 32'(exp_start));
    check("mdu_out", mdu_out, exp_out);
    @(posedge clk);
    if (cyc < m_done) begin
      cyc++;
      if (cyc == m_done && m_pend) {m_hi, m_lo} = m_res;
    end else begin
      cyc++;
      if (exp_start) begin
        m_done = cyc + latency(o);
        m_pend = !((o == 4'd3 || o == 4'd4) && b == 32'h0);
        m_res  = ref_result(o, a, b, {m_hi, m_lo});
      end else if (!r) begin
        if (o == 4'd7) m_hi = a;
        if (o == 4'd8) m_lo = a;
      end
    end
    #1;
    check("busy", 32'(busy), 32'(cyc < m_done));
    check("hi", hi, m_hi);
    check("lo", lo, m_lo);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(4'd0, 32'h0, 32'h0, 1'b0);
  endtask

  // Asynchronous reset between edges; effect must be visible before the next edge.
  task automatic async_reset();
    @(negedge clk);
    op = 4'd0; req = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    m_hi = '0; m_lo = '0; m_pend = 1'b0; m_done = cyc;
    @(negedge clk);
    reset = 1'b0;
  endtask

  function automatic logic [31:0] rand_opnd();
    case ($urandom_range(0, 4))
      0: return 32'h0;
      1: return $urandom_range(0, 20);
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF - $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset = 1'b1; op = 4'd0; a_in = '0; b_in = '0; req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("init_busy", 32'(busy), 32'h0);
    check("init_start", 32'(start), 32'h0);
    check("init_hi", hi, 32'h0);
    check("init_lo", lo, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // mult / multu with 0xFFFFFFFF x 2
    step(4'd1, 32'hFFFF_FFFF, 32'd2, 1'b0);
    idle(MULT_N);
    check("plan_mult_hi", hi, 32'hFFFF_FFFF);
    check("plan_mult_lo", lo, 32'hFFFF_FFFE);
    step(4'd2, 32'hFFFF_FFFF, 32'd2, 1'b0);
    idle(MULT_N);
    check("plan_multu_hi", hi, 32'h0000_0001);
    check("plan_multu_lo", lo, 32'hFFFF_FFFE);

    // signed divide -7 / 2
    step(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
    idle(DIV_N);
    check("plan_div_lo", lo, 32'hFFFF_FFFD);
    check("plan_div_hi", hi, 32'hFFFF_FFFF);

    // divide by zero keeps HI/LO
    step(4'd7, 32'h11, 32'h0, 1'b0);
    step(4'd8, 32'h22, 32'h0, 1'b0);
    step(4'd4, 32'd7, 32'd0, 1'b0);
    idle(DIV_N);
    check("plan_div0_hi", hi, 32'h11);
    check("plan_div0_lo", lo, 32'h22);

    // moves and reads
    step(4'd7, 32'h1234_5678, 32'h0, 1'b0);
    check("plan_mthi", hi, 32'h1234_5678);
    step(4'd8, 32'hCAFE_BABE, 32'h0, 1'b0);
    step(4'd6, 32'h0, 32'h0, 1'b0);
    check("plan_mflo", mdu_out, 32'hCAFE_BABE);

    // second mult and mthi while busy are ignored; Req mid-run does not cancel
    step(4'd1, 32'd3, 32'd4, 1'b0);
    step(4'd1, 32'd100, 32'd100, 1'b0);
    step(4'd7, 32'hDEAD_BEEF, 32'h0, 1'b0);
    step(4'd0, 32'h0, 32'h0, 1'b1);
    idle(MULT_N);
    check("plan_busy_ign_lo", lo, 32'd12);
    check("plan_busy_ign_hi", hi, 32'd0);

    // Req suppression
    step(4'd1, 32'd5, 32'd5, 1'b1);
    step(4'd7, 32'h5555_5555, 32'h0, 1'b1);
    check("plan_req_hi", hi, 32'd0);
    check("plan_req_lo", lo, 32'd12);

    // reset in the middle of a divide, then no late writeback
    step(4'd3, 32'd100, 32'd7, 1'b0);
    idle(3);
    async_reset();
    idle(DIV_N + 2);
    check("plan_rst_hi", hi, 32'h0);
    check("plan_rst_lo", lo, 32'h0);

    // accumulate op 9
    step(4'd7, 32'h0, 32'h0, 1'b0);
    step(4'd8, 32'hFFFF_FFFF, 32'h0, 1'b0);
    step(4'd9, 32'd1, 32'd1, 1'b0);
    idle(MULT_N);
`ifdef MDU_MADD_EN
    check("plan_madd_hi", hi, 32'd1);
    check("plan_madd_lo", lo, 32'd0);
`else
    check("plan_nomadd_hi", hi, 32'd0);
    check("plan_nomadd_lo", lo, 32'hFFFF_FFFF);
`endif

    // randomized traffic
    for (int i = 0; i < 600; i++)
      step(4'($urandom_range(0, 15)), rand_opnd(), rand_opnd(), ($urandom_range(0, 7) == 0));
    idle(DIV_N + 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
